// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB first, repeat_cnt
// times, with gap idle cycles between copies. Since repeat is a reserved word, the count port is repeat_cnt.
module seq_pattern_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] sreg;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gapcnt;
   logic [CNT_W-1:0] copies;
   logic [BW-1:0]    bitcnt;

   // Outputs are flops updated alongside the state, so they describe the cycle
   // that the new state represents; sreg holds the bits still to go after dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pat_q      <= '0;
         sreg       <= '0;
         gap_q      <= '0;
         gapcnt     <= '0;
         copies     <= '0;
         bitcnt     <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (repeat_cnt == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     pat_q      <= pattern;
                     gap_q      <= gap;
                     copies     <= repeat_cnt;
                     sreg       <= pattern << 1;
                     bitcnt     <= BW'(PAT_W - 1);
                     dout       <= pattern[PAT_W-1];
                     dout_valid <= 1'b1;
                     busy       <= 1'b1;
                     state      <= SEND;
                  end
               end
            end
            SEND: begin
               if (abort) begin
                  state      <= IDLE;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end else if (bitcnt != '0) begin
                  dout   <= sreg[PAT_W-1];
                  sreg   <= sreg << 1;
                  bitcnt <= bitcnt - BW'(1);
               end else if (copies == CNT_W'(1)) begin
                  // LSB of the final copy is on the wire now
                  state      <= DONE;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  copies     <= '0;
               end else begin
                  copies <= copies - CNT_W'(1);
                  if (gap_q == '0) begin
                     sreg   <= pat_q << 1;
                     bitcnt <= BW'(PAT_W - 1);
                     dout   <= pat_q[PAT_W-1];
                  end else begin
                     state      <= GAP;
                     gapcnt     <= gap_q - GAP_W'(1);
                     dout       <= 1'b0;
                     dout_valid <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (gapcnt == '0) begin
                  state      <= SEND;
                  sreg       <= pat_q << 1;
                  bitcnt     <= BW'(PAT_W - 1);
                  dout       <= pat_q[PAT_W-1];
                  dout_valid <= 1'b1;
               end else begin
                  gapcnt <= gapcnt - GAP_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a per-cycle expectation queue built from a reference
// model, driven from a vector table plus hand-written abort/reset sequences.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start, abort;
   logic [3:0] pattern;
   logic [3:0] rpt;
   logic [2:0] gp;
   logic       dout, dout_valid, busy, done;

   seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .pattern(pattern), .repeat_cnt(rpt), .gap(gp),
      .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic d;
      logic v;
      logic b;
      logic dn;
   } obs_t;

   typedef struct {
      logic [3:0] pat;
      int         rep;
      int         gap;
      bit         noisy;
      int         abort_at;
      int         exp_done;
   } vec_t;

   obs_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   localparam obs_t IDLE_O = '{d: 1'b0, v: 1'b0, b: 1'b0, dn: 1'b0};

   function automatic obs_t cur();
      return '{d: dout, v: dout_valid, b: busy, dn: done};
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = cur();
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got dout/valid/busy/done=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference behaviour: one entry per cycle after the accepting edge.
   task automatic push_model(input logic [3:0] pat, input int rep, input int gap);
      for (int c = 0; c < rep; c++) begin
         for (int b = 3; b >= 0; b--) q.push_back('{d: pat[b], v: 1'b1, b: 1'b1, dn: 1'b0});
         if (c < rep - 1)
            for (int g = 0; g < gap; g++) q.push_back('{d: 1'b0, v: 1'b0, b: 1'b1, dn: 1'b0});
      end
      q.push_back('{d: 1'b0, v: 1'b0, b: 1'b0, dn: 1'b1});
      q.push_back(IDLE_O);
      q.push_back(IDLE_O);
   endtask

   // Pops one expectation per cycle; inputs are scrambled while busy to show
   // the captured values are what gets sent.
   task automatic drain(input string name, input bit noisy, input int abort_at, output int done_at);
      int k = 0;
      done_at = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         k++;
         check(name, q.pop_front());
         if (done && done_at == 0) done_at = k;
         start   = noisy && (q.size() > 2);
         abort   = (k == abort_at);
         pattern = 4'($urandom);
         rpt     = 4'($urandom);
         gp      = 3'($urandom);
         if (k == abort_at) begin
            q.delete();
            repeat (3) q.push_back(IDLE_O);
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   vec_t tbl[9];
   int   dat;

   initial begin
      tbl[0] = '{4'b1010,  3, 0, 1'b0, 0, 13};
      tbl[1] = '{4'b1101,  2, 2, 1'b0, 0, 11};
      tbl[2] = '{4'b0000,  0, 5, 1'b0, 0,  1};
      tbl[3] = '{4'b0110,  1, 7, 1'b0, 0,  5};
      tbl[4] = '{4'b1001, 15, 1, 1'b0, 0, 75};
      tbl[5] = '{4'b1110,  2, 3, 1'b1, 0, 12};
      tbl[6] = '{4'b1011,  2, 1, 1'b0, 2,  0};
      tbl[7] = '{4'b1101,  2, 3, 1'b0, 5,  0};
      tbl[8] = '{4'b0111,  3, 0, 1'b0, 0, 13};

      reset_n = 1'b0; start = 1'b0; abort = 1'b0;
      pattern = 4'hF; rpt = 4'h3; gp = 3'h1;
      repeat (2) @(negedge clk);
      check("reset_state", IDLE_O);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         pattern = tbl[i].pat; rpt = 4'(tbl[i].rep); gp = 3'(tbl[i].gap);
         start = 1'b1; abort = 1'b0;
         q.delete();
         push_model(tbl[i].pat, tbl[i].rep, tbl[i].gap);
         drain($sformatf("vec%0d", i), tbl[i].noisy, tbl[i].abort_at, dat);
         check_int($sformatf("vec%0d_done_cycle", i), dat, tbl[i].exp_done);
      end

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      pattern = 4'b1111; rpt = 4'd2; gp = 3'd0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", IDLE_O);
      @(negedge clk);
      check("start_abort_idle2", IDLE_O);

      // asynchronous reset mid-SEND, then a fresh start on the first edge after release
      @(negedge clk);
      pattern = 4'b1100; rpt = 4'd3; gp = 3'd1; start = 1'b1;
      q.delete();
      push_model(4'b1100, 3, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         check("pre_reset", q.pop_front());
      end
      #1 reset_n = 1'b0;
      #1 check("reset_async", IDLE_O);
      @(negedge clk);
      check("reset_hold", IDLE_O);
      reset_n = 1'b1;
      pattern = 4'b0101; rpt = 4'd2; gp = 3'd0; start = 1'b1;
      q.delete();
      push_model(4'b0101, 2, 0);
      drain("post_reset", 1'b0, 0, dat);
      check_int("post_reset_done_cycle", dat, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
